// File: rtl/sync_fifo_buffer.sv
// Synchronous FIFO: DEPTH words in a simple dual-port RAM plus one word in the registered output stage.
// With CIRCULAR_BUFFER set, writes never stall and a full buffer discards its oldest word.
module sync_fifo_buffer #(
    parameter int WORD_WIDTH      = 8,
    parameter int DEPTH           = 16,
    parameter     RAMSTYLE        = "",
    parameter int CIRCULAR_BUFFER = 0
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  input_valid,
    output logic                  input_ready,
    input  logic [WORD_WIDTH-1:0] input_data,
    output logic                  output_valid,
    input  logic                  output_ready,
    output logic [WORD_WIDTH-1:0] output_data
);

    localparam int            AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam bit            CIRCULAR  = (CIRCULAR_BUFFER != 0);

    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic          wr_wrap;
    logic          rd_wrap;
    logic          addr_eq;
    logic          empty;
    logic          full;
    logic          insert;
    logic          remove;
    logic          load;
    logic          read_en;
    logic          write_en;

    // Returns {wrap, addr} after one step; the wrap bit flips each time the address rolls over.
    function automatic logic [AW:0] next_ptr(input logic wrap, input logic [AW-1:0] addr);
        logic [AW:0] result;
        if (addr == LAST_ADDR) begin
            result = {~wrap, {AW{1'b0}}};
        end else begin
            result = {wrap, addr + AW'(1)};
        end
        return result;
    endfunction

    assign addr_eq     = (wr_addr == rd_addr);
    assign empty       = addr_eq && (wr_wrap == rd_wrap);
    assign full        = addr_eq && (wr_wrap != rd_wrap);
    assign input_ready = CIRCULAR ? 1'b1 : !full;
    assign insert      = input_valid && input_ready;
    assign remove      = (output_valid && output_ready) || (CIRCULAR && full && insert);
    assign load        = remove || (!output_valid && !empty);
    assign read_en     = load && !empty && !clear;
    assign write_en    = insert && !clear;

    always_ff @(posedge clock) begin
        if (clear) begin
            wr_addr      <= '0;
            wr_wrap      <= 1'b0;
            rd_addr      <= '0;
            rd_wrap      <= 1'b0;
            output_valid <= 1'b0;
        end else begin
            if (insert) begin
                {wr_wrap, wr_addr} <= next_ptr(wr_wrap, wr_addr);
            end
            if (read_en) begin
                {rd_wrap, rd_addr} <= next_ptr(rd_wrap, rd_addr);
            end
            if (load) begin
                output_valid <= !empty;
            end
        end
    end

    // Read-before-write on a shared address returns the old word; no forwarding path.
    if (RAMSTYLE == "") begin : g_mem
        logic [WORD_WIDTH-1:0] mem [DEPTH];

        always_ff @(posedge clock) begin
            if (write_en) begin
                mem[wr_addr] <= input_data;
            end
            if (read_en) begin
                output_data <= mem[rd_addr];
            end
        end
    end else begin : g_mem_hinted
        (* ramstyle = RAMSTYLE, ram_style = RAMSTYLE *)
        logic [WORD_WIDTH-1:0] mem [DEPTH];

        always_ff @(posedge clock) begin
            if (write_en) begin
                mem[wr_addr] <= input_data;
            end
            if (read_en) begin
                output_data <= mem[rd_addr];
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_buffer.sv
// Bench for sync_fifo_buffer: three instances (DEPTH 4, DEPTH 3, DEPTH 4 circular) share stimulus;
// each scenario checks one instance against a queue-based model of occupancy, order and latency.
module tb_sync_fifo_buffer;

    logic       clock = 1'b0;
    logic       clear;
    logic       input_valid;
    logic       output_ready;
    logic [7:0] input_data;

    logic       r4, v4, r3, v3, rc, vc;
    logic [7:0] d4, d3, dc;

    always #5 clock = ~clock;

    sync_fifo_buffer #(.WORD_WIDTH(8), .DEPTH(4), .RAMSTYLE(""), .CIRCULAR_BUFFER(0)) u_d4 (
        .clock(clock), .clear(clear), .input_valid(input_valid), .input_ready(r4),
        .input_data(input_data), .output_valid(v4), .output_ready(output_ready), .output_data(d4));

    sync_fifo_buffer #(.WORD_WIDTH(8), .DEPTH(3), .RAMSTYLE(""), .CIRCULAR_BUFFER(0)) u_d3 (
        .clock(clock), .clear(clear), .input_valid(input_valid), .input_ready(r3),
        .input_data(input_data), .output_valid(v3), .output_ready(output_ready), .output_data(d3));

    sync_fifo_buffer #(.WORD_WIDTH(8), .DEPTH(4), .RAMSTYLE(""), .CIRCULAR_BUFFER(1)) u_c4 (
        .clock(clock), .clear(clear), .input_valid(input_valid), .input_ready(rc),
        .input_data(input_data), .output_valid(vc), .output_ready(output_ready), .output_data(dc));

    int checks = 0;
    int passed = 0;

    // Reference model: words held (oldest first) and the cycle each was accepted.
    logic [7:0] q[$];
    int         qt[$];
    int         cyc;
    logic       e_rdy, e_vld;
    logic [7:0] e_dat;
    logic [7:0] got[$];

    function automatic void model_reset();
        q.delete();
        qt.delete();
        cyc = 0;
    endfunction

    // A word is visible two cycles after acceptance; capacity is DEPTH+1 words.
    function automatic void model_eval(int depth, bit circ);
        e_rdy = circ || (q.size() < depth + 1);
        e_vld = (q.size() > 0) && (qt[0] + 2 <= cyc);
        e_dat = (q.size() > 0) ? q[0] : 8'h00;
    endfunction

    function automatic void model_step(int depth, bit circ);
        bit ins, hs;
        ins = input_valid && e_rdy;
        hs  = e_vld && output_ready;
        if (hs || (circ && ins && q.size() == depth + 1)) begin
            void'(q.pop_front());
            void'(qt.pop_front());
        end
        if (ins) begin
            q.push_back(input_data);
            qt.push_back(cyc);
        end
        cyc++;
    endfunction

    task automatic do_clear();
        @(negedge clock);
        clear        = 1'b1;
        input_valid  = 1'b0;
        output_ready = 1'b0;
        input_data   = 8'h00;
        @(negedge clock);
        clear = 1'b0;
        model_reset();
        got.delete();
    endtask

    task automatic test_reset();
        do_clear();
        checks++; if (r4 !== 1'b1) $display("FAIL reset.ready_d4 got=%b exp=1", r4); else passed++;
        checks++; if (v4 !== 1'b0) $display("FAIL reset.valid_d4 got=%b exp=0", v4); else passed++;
        checks++; if (r3 !== 1'b1) $display("FAIL reset.ready_d3 got=%b exp=1", r3); else passed++;
        checks++; if (v3 !== 1'b0) $display("FAIL reset.valid_d3 got=%b exp=0", v3); else passed++;
        checks++; if (rc !== 1'b1) $display("FAIL reset.ready_c4 got=%b exp=1", rc); else passed++;
        checks++; if (vc !== 1'b0) $display("FAIL reset.valid_c4 got=%b exp=0", vc); else passed++;
    endtask

    task automatic test_single();
        do_clear();
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            input_valid  = (k == 0);
            input_data   = 8'hA5;
            output_ready = (k == 2);
            model_eval(4, 1'b0);
            checks++; if (r4 !== e_rdy) $display("FAIL single.ready cyc=%0d got=%b exp=%b", cyc, r4, e_rdy); else passed++;
            checks++; if (v4 !== e_vld) $display("FAIL single.valid cyc=%0d got=%b exp=%b", cyc, v4, e_vld); else passed++;
            if (k == 2) begin
                checks++; if (v4 !== 1'b1 || d4 !== 8'hA5) $display("FAIL single.latency got v=%b d=%h exp v=1 d=a5", v4, d4); else passed++;
            end
            if (k == 3) begin
                checks++; if (v4 !== 1'b0) $display("FAIL single.drained got=%b exp=0", v4); else passed++;
            end
            @(posedge clock);
            model_step(4, 1'b0);
        end
    endtask

    task automatic test_fill();
        do_clear();
        for (int k = 0; k < 14; k++) begin
            @(negedge clock);
            input_valid  = (k < 6);
            input_data   = 8'(k + 1);
            output_ready = (k >= 6);
            model_eval(4, 1'b0);
            checks++; if (r4 !== e_rdy) $display("FAIL fill.ready cyc=%0d got=%b exp=%b", cyc, r4, e_rdy); else passed++;
            checks++; if (v4 !== e_vld) $display("FAIL fill.valid cyc=%0d got=%b exp=%b", cyc, v4, e_vld); else passed++;
            if (e_vld) begin
                checks++; if (d4 !== e_dat) $display("FAIL fill.data cyc=%0d got=%h exp=%h", cyc, d4, e_dat); else passed++;
            end
            if (k == 5) begin
                checks++; if (r4 !== 1'b0) $display("FAIL fill.full_ready got=%b exp=0", r4); else passed++;
            end
            if (v4 === 1'b1 && output_ready) got.push_back(d4);
            @(posedge clock);
            model_step(4, 1'b0);
        end
        checks++; if (got.size() != 5) $display("FAIL fill.count got=%0d exp=5", got.size()); else passed++;
        for (int i = 0; i < got.size() && i < 5; i++) begin
            checks++; if (got[i] !== 8'(i + 1)) $display("FAIL fill.order idx=%0d got=%h exp=%h", i, got[i], 8'(i + 1)); else passed++;
        end
    endtask

    task automatic test_stream();
        int first;
        int last;
        first = -1;
        last  = -1;
        do_clear();
        for (int k = 0; k < 14; k++) begin
            @(negedge clock);
            input_valid  = (k < 10);
            input_data   = 8'(k);
            output_ready = 1'b1;
            model_eval(3, 1'b0);
            checks++; if (r3 !== e_rdy) $display("FAIL stream.ready cyc=%0d got=%b exp=%b", cyc, r3, e_rdy); else passed++;
            checks++; if (v3 !== e_vld) $display("FAIL stream.valid cyc=%0d got=%b exp=%b", cyc, v3, e_vld); else passed++;
            if (e_vld) begin
                checks++; if (d3 !== e_dat) $display("FAIL stream.data cyc=%0d got=%h exp=%h", cyc, d3, e_dat); else passed++;
            end
            if (v3 === 1'b1) begin
                got.push_back(d3);
                if (first < 0) first = k;
                last = k;
            end
            @(posedge clock);
            model_step(3, 1'b0);
        end
        checks++; if (first != 2 || last != 11) $display("FAIL stream.timing got first=%0d last=%0d exp first=2 last=11", first, last); else passed++;
        checks++; if (got.size() != 10) $display("FAIL stream.count got=%0d exp=10", got.size()); else passed++;
        for (int i = 0; i < got.size() && i < 10; i++) begin
            checks++; if (got[i] !== 8'(i)) $display("FAIL stream.order idx=%0d got=%h exp=%h", i, got[i], 8'(i)); else passed++;
        end
    endtask

    task automatic test_circular();
        logic [7:0] want[5];
        want = '{8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        do_clear();
        for (int k = 0; k < 16; k++) begin
            @(negedge clock);
            input_valid  = (k < 7);
            input_data   = 8'(k + 1);
            output_ready = (k >= 8);
            model_eval(4, 1'b1);
            checks++; if (rc !== 1'b1) $display("FAIL circ.ready cyc=%0d got=%b exp=1", cyc, rc); else passed++;
            checks++; if (vc !== e_vld) $display("FAIL circ.valid cyc=%0d got=%b exp=%b", cyc, vc, e_vld); else passed++;
            if (e_vld) begin
                checks++; if (dc !== e_dat) $display("FAIL circ.data cyc=%0d got=%h exp=%h", cyc, dc, e_dat); else passed++;
            end
            if (vc === 1'b1 && output_ready) got.push_back(dc);
            @(posedge clock);
            model_step(4, 1'b1);
        end
        checks++; if (got.size() != 5) $display("FAIL circ.count got=%0d exp=5", got.size()); else passed++;
        for (int i = 0; i < got.size() && i < 5; i++) begin
            checks++; if (got[i] !== want[i]) $display("FAIL circ.order idx=%0d got=%h exp=%h", i, got[i], want[i]); else passed++;
        end
    endtask

    task automatic test_clear_mid();
        do_clear();
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            input_valid  = (k < 3);
            input_data   = 8'(8'h10 + k);
            output_ready = 1'b0;
            @(posedge clock);
        end
        do_clear();
        checks++; if (v4 !== 1'b0) $display("FAIL clrmid.valid got=%b exp=0", v4); else passed++;
        checks++; if (r4 !== 1'b1) $display("FAIL clrmid.ready got=%b exp=1", r4); else passed++;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            input_valid  = (k == 0);
            input_data   = 8'h5A;
            output_ready = 1'b1;
            model_eval(4, 1'b0);
            checks++; if (v4 !== e_vld) $display("FAIL clrmid.valid cyc=%0d got=%b exp=%b", cyc, v4, e_vld); else passed++;
            if (v4 === 1'b1) got.push_back(d4);
            @(posedge clock);
            model_step(4, 1'b0);
        end
        checks++; if (got.size() != 1) $display("FAIL clrmid.count got=%0d exp=1", got.size()); else passed++;
        if (got.size() > 0) begin
            checks++; if (got[0] !== 8'h5A) $display("FAIL clrmid.data got=%h exp=5a", got[0]); else passed++;
        end
    endtask

    task automatic test_random_normal();
        do_clear();
        for (int k = 0; k < 1000; k++) begin
            @(negedge clock);
            input_valid  = 1'($urandom_range(0, 1));
            input_data   = 8'($urandom);
            output_ready = 1'($urandom_range(0, 1));
            model_eval(4, 1'b0);
            checks++; if (r4 !== e_rdy) $display("FAIL rand.ready cyc=%0d got=%b exp=%b held=%0d", cyc, r4, e_rdy, q.size()); else passed++;
            checks++; if (v4 !== e_vld) $display("FAIL rand.valid cyc=%0d got=%b exp=%b", cyc, v4, e_vld); else passed++;
            if (e_vld) begin
                checks++; if (d4 !== e_dat) $display("FAIL rand.data cyc=%0d got=%h exp=%h", cyc, d4, e_dat); else passed++;
            end
            @(posedge clock);
            model_step(4, 1'b0);
        end
    endtask

    task automatic test_random_circular();
        do_clear();
        for (int k = 0; k < 400; k++) begin
            @(negedge clock);
            input_valid  = ($urandom_range(0, 3) != 0);
            input_data   = 8'($urandom);
            output_ready = ($urandom_range(0, 3) == 0);
            model_eval(4, 1'b1);
            checks++; if (rc !== 1'b1) $display("FAIL randc.ready cyc=%0d got=%b exp=1", cyc, rc); else passed++;
            checks++; if (vc !== e_vld) $display("FAIL randc.valid cyc=%0d got=%b exp=%b", cyc, vc, e_vld); else passed++;
            if (e_vld) begin
                checks++; if (dc !== e_dat) $display("FAIL randc.data cyc=%0d got=%h exp=%h", cyc, dc, e_dat); else passed++;
            end
            @(posedge clock);
            model_step(4, 1'b1);
        end
    endtask

    initial begin
        clear        = 1'b1;
        input_valid  = 1'b0;
        output_ready = 1'b0;
        input_data   = 8'h00;
        model_reset();
        test_reset();
        test_single();
        test_fill();
        test_stream();
        test_circular();
        test_clear_mid();
        test_random_normal();
        test_random_circular();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/sync_fifo_buffer.md
SYNC_FIFO_BUFFER -- requirements
Module: sync_fifo_buffer

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 8: data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 16: storage memory entries (>=2); any integer is allowed, not only powers of 2.
REQ-003 SHALL have parameter RAMSTYLE, default "": synthesis RAM-style hint passed to the storage memory.
REQ-004 SHALL have parameter CIRCULAR_BUFFER, default 0: nonzero enables circular (overwrite-oldest) mode.
REQ-005 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port clear, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port input_valid, input, 1: upstream offers input_data.
REQ-008 SHALL have port input_ready, output, 1: block accepts data this cycle.
REQ-009 SHALL have port input_data, input, WORD_WIDTH: write data.
REQ-010 SHALL have port output_valid, output, 1: output_data holds an unread word.
REQ-011 SHALL have port output_ready, input, 1: downstream accepts output_data.
REQ-012 SHALL have port output_data, output, WORD_WIDTH: registered read data.

Function
REQ-013 SHALL store words in a simple dual-port memory of DEPTH entries with synchronous write and synchronous registered read; output_data is the read register, changing only on an enabled read.
REQ-014 SHALL keep read/write address counters of width clog2(DEPTH), each incrementing by 1 per operation and wrapping from DEPTH-1 to 0, plus one wrap bit per counter that toggles on each wrap.
REQ-015 SHALL define empty = addresses equal and wrap bits equal; full = addresses equal and wrap bits different.
REQ-016 SHALL drive input_ready = !full, or constant 1 when CIRCULAR_BUFFER != 0; input_ready SHALL NOT depend combinationally on output_ready.
REQ-017 SHALL perform insert = input_valid & input_ready: write input_data at the write address and advance the write address.
REQ-018 SHALL perform remove = (output_valid & output_ready), or (circular mode & full & insert).
REQ-019 SHALL load the output register when remove, or when !output_valid & !empty; on a load, it SHALL set output_valid = !empty, and if !empty it SHALL read memory at the read address and advance the read address.
REQ-020 SHALL give a latency of 2 cycles from input handshake to output_valid=1 with that word when idle, and sustain 1 word/cycle when streaming.
REQ-021 SHALL have a total capacity of DEPTH+1 words (DEPTH in memory plus 1 in the output register); in normal mode, input_ready SHALL fall once that count is held.
REQ-022 SHALL, in circular mode when full, write the new word and drop the word held in the output register, replacing it with the oldest memory word; output_valid SHALL stay 1.
REQ-023 SHALL, on a same-address read and write in the same cycle (circular full case only), return the old stored data; no write-forwarding logic.
REQ-024 SHALL deliver words strictly in FIFO order, each exactly once.

Reset
REQ-025 SHALL, while clear=1, set both addresses to 0, both wrap bits to 0 and output_valid to 0 on the next edge; clear overrides insert/remove counting.
REQ-026 SHALL drive input_ready=1 after clear; output_data and memory contents are not cleared.
REQ-027 SHALL power up (initial values) in the post-clear state.

Verification (WORD_WIDTH=8)
REQ-028 SHALL pass this scenario (DEPTH=4): after clear, write 0xA5 in cycle 0 -> output_valid=1, output_data=0xA5 at cycle 2; output_ready=1 -> output_valid=0 the next cycle.
REQ-029 SHALL pass this scenario (DEPTH=4): with output_ready=0, offer 0x01..0x06 back-to-back -> 0x01..0x05 accepted, input_ready=0 thereafter; then output_ready=1 -> 0x01..0x05 emerge on consecutive cycles, then output_valid=0.
REQ-030 SHALL pass this scenario (DEPTH=3, non-power-of-2): stream 0x00..0x09 with input_valid=1, output_ready=1 -> all ten words emerge in order, 1 per cycle after 2-cycle latency, across address wrap.
REQ-031 SHALL pass this scenario (DEPTH=4, CIRCULAR_BUFFER=1): output_ready=0, write 0x01..0x07 -> input_ready always 1; then draining yields 0x03,0x04,0x05,0x06,0x07.
REQ-032 SHALL pass this scenario (DEPTH=4): with 3 words held, pulse clear 1 cycle -> next cycle output_valid=0, input_ready=1; write 0x5A -> 0x5A is the only word read out.
REQ-033 SHALL pass this scenario (DEPTH=4): random input_valid/output_ready toggling over 1000 cycles -> output sequence equals input sequence, and input_ready=0 only when holding 5 words.
